psum_collector: RTL
===================

Name: psum_collector

Overview:
- Downstream stage of the 8-lane MAC array; consumes the eight 8-bit partial sums and per-lane valids.
- Accumulates each lane across a configurable number of input-channel tiles, then applies arithmetic right shift, ReLU and clamp to 8 bits.
- Packs all eight lane results into one 64-bit output word, delivered over a valid/ready handshake to the output writer.

Parameters:
- LANES, 8, number of MAC lanes / output channels
- DW, 8, partial-sum and result width per lane
- ACC_W, 16, per-lane accumulator width (signed)
- TW, 8, width of tile-count config

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- psum_i  in  DW*LANES  lane k partial sum at [DW*k +: DW], signed two's complement
- vld_i  in  LANES  lane k partial sum valid (one-cycle pulse per tile)
- cfg_tiles  in  TW  tiles per output group; 0 treated as 1; sampled per lane when that lane's tile count is 0
- cfg_shift  in  3  arithmetic right shift applied before ReLU/clamp; static during a group
- dout  out  DW*LANES  packed results, lane k at [DW*k +: DW], unsigned
- out_vld  out  1  dout valid
- out_rdy  in  1  consumer accepts dout when out_vld & out_rdy
- ovf_err  out  1  sticky; lane completed a group while its previous result was undrained
- grp_cnt  out  16  number of output words accepted, wraps at 2^16

Behaviour:
- Reset (rst=1 at clock edge): all accumulators, tile counters, done bits and result regs cleared; dout=0, out_vld=0, ovf_err=0, grp_cnt=0; FSM state is COLLECT. Reset overrides all other events in the same cycle, including mid-group and mid-handshake.
- Per lane k, on vld_i[k]:
  - If cnt==0: latch tiles_k = max(cfg_tiles,1) and set acc = sext(psum).
  - Otherwise acc = acc + sext(psum).
  - cnt increments.
- Accumulator range: worst case 255 × (−128) = −32640, so ACC_W=16 cannot overflow and no accumulator saturation is needed.
- Lane completion occurs when (cnt+1)==tiles_k on a vld cycle:
  - res_k = clamp(relu(new_acc >>> cfg_shift), 0, 255), where relu maps negative values to 0; the arithmetic uses the new sum including this cycle's psum.
  - done[k] set; cnt returns to 0.
- Completion with done[k] already set and no handshake in the same cycle: result discarded, res_k and done[k] unchanged, ovf_err set (cleared only by rst). Accumulator and counter still restart for the next group.
- FSM:
  - COLLECT: out_vld=0. When &done==1, go to HOLD; dout is loaded from res at that edge.
  - HOLD: out_vld=1 and dout stable. On out_vld&out_rdy: clear all done bits, increment grp_cnt, go to COLLECT.
- Latency: final vld_i of the last lane at cycle t → done at t+1 → out_vld=1 at t+2. With out_rdy held high, back-to-back groups are supported as long as each lane's next completion comes ≥2 cycles after the previous one.
- Simultaneous handshake and lane completion: the handshake clears done, then the completion writes res_k and sets done[k]. This is not an overflow.
- Lanes are fully independent; any mix of vld_i bits per cycle is legal.
- cfg_shift change mid-group: undefined result; caller must hold it stable.

Decomposition:
- Shared package holds LANES, DW, ACC_W, TW defaults, the FSM state encoding (COLLECT, HOLD) and a relu_clamp function (signed ACC_W in, shift in, DW unsigned out).
- One sub-module psum_lane_acc (acc, cnt, tiles_k, done, res, ovf pulse), instantiated LANES times via generate.
- Top level holds the FSM, the dout register, grp_cnt and the sticky ovf_err.

Test Plan:
1. cfg_tiles=1, shift=0; all vld_i=8'hFF for one cycle with lane k psum=10*(k+1) → out_vld at t+2, dout=64'h50463C32281E140A; out_rdy=1 → grp_cnt=1.
2. cfg_tiles=3; each lane receives psum=8'hFB (−5) three times → acc −15 → dout=0 for all lanes, out_vld after the last tile.
3. cfg_tiles=4, psum=127 on every lane → 508: shift=0 gives 255 (0xFF) per lane; repeat with shift=2 → 127 (0x7F).
4. Backpressure: group 1 complete, out_rdy=0; lane 0 completes group 2 (tiles=1, psum=9) → ovf_err=1, dout unchanged; then out_rdy=1 → handshake, done cleared, grp_cnt=1.
5. Handshake and completion in the same cycle: out_rdy=1 with lane 3 vld psum=7 (tiles=1) → ovf_err stays 0, done[3]=1, res_3=7.
6. Reset mid-operation: cfg_tiles=3, two tiles delivered on all lanes, then rst=1 → all outputs 0; three fresh tiles of psum=1 → dout bytes all 3 (no carry-over from before reset).

Source files
------------

// File: rtl/psum_collector_pkg.sv
// psum_collector_pkg
//   Shared definitions for the partial-sum collector:
//   - default geometry (LANES, DW, ACC_W, TW)
//   - output FSM state encoding
//   - relu_clamp: arithmetic right shift, then clamp to the unsigned range [0, 2^DW-1]
package psum_collector_pkg;

  localparam int LANES = 8;   // MAC lanes / output channels
  localparam int DW    = 8;   // partial-sum and result width per lane
  localparam int ACC_W = 16;  // signed per-lane accumulator width
  localparam int TW    = 8;   // tile-count config width

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,  // waiting for every lane to finish its group
    ST_HOLD    = 1'b1   // packed word presented, waiting for the consumer
  } state_t;

  // Shift first, then ReLU, then saturate to DW bits.
  // A negative accumulator stays negative after an arithmetic shift, so the
  // sign bit alone decides the ReLU. Any set bit above DW-1 means the value
  // is above the output range.
  function automatic logic [DW-1:0] relu_clamp(input logic signed [ACC_W-1:0] acc,
                                               input logic [2:0] shift);
    logic signed [ACC_W-1:0] shifted;
    logic [DW-1:0] res;
    shifted = acc >>> shift;
    if (shifted[ACC_W-1]) begin
      res = '0;
    end else if (|shifted[ACC_W-2:DW]) begin
      res = '1;
    end else begin
      res = shifted[DW-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/psum_collector_lane_acc.sv
// psum_lane_acc
//   One lane of the collector. It accumulates sign-extended partial sums
//   over tiles_k tiles, then produces a shifted/ReLU/clamped result and
//   raises done until the top-level handshake clears it.
//
//   clk, rst   : clock, synchronous active-high reset
//   psum, vld  : lane partial sum (signed) and its one-cycle valid
//   cfg_tiles  : tiles per group (0 means 1), latched on the first tile
//   cfg_shift  : arithmetic right shift applied at completion
//   clr_done   : top-level handshake this cycle; clears done
//   done, res  : result ready flag and the registered result
//   ovf        : pulse, a completion found the previous result undrained
module psum_lane_acc
  import psum_collector_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] psum,
  input  logic          vld,
  input  logic [TW-1:0] cfg_tiles,
  input  logic [2:0]    cfg_shift,
  input  logic          clr_done,
  output logic          done,
  output logic [DW-1:0] res,
  output logic          ovf
);

  logic signed [ACC_W-1:0] acc;
  logic [TW-1:0]           cnt;
  logic [TW-1:0]           tiles_k;

  logic signed [ACC_W-1:0] psum_sext;
  logic signed [ACC_W-1:0] new_acc;
  logic [TW-1:0]           tiles_eff;
  logic [TW-1:0]           cnt_inc;
  logic                    complete;

  // On the first tile of a group the live config is used, so a lane that
  // completes in a single tile sees the correct group size immediately.
  always_comb begin
    psum_sext = {{(ACC_W-DW){psum[DW-1]}}, psum};
    if (cnt == '0) begin
      new_acc   = psum_sext;
      tiles_eff = (cfg_tiles == '0) ? TW'(1) : cfg_tiles;
    end else begin
      new_acc   = acc + psum_sext;
      tiles_eff = tiles_k;
    end
    cnt_inc  = cnt + TW'(1);
    complete = vld && (cnt_inc == tiles_eff);
    // A handshake in the same cycle frees the slot, so that is not an overflow.
    ovf      = complete && done && !clr_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      tiles_k <= '0;
      done    <= 1'b0;
      res     <= '0;
    end else begin
      if (vld) begin
        acc <= new_acc;
        if (cnt == '0) begin
          tiles_k <= tiles_eff;
        end
        cnt <= complete ? '0 : cnt_inc;
      end
      // Clear first, then a completion may set it again in the same cycle.
      if (clr_done) begin
        done <= 1'b0;
      end
      if (complete && !ovf) begin
        done <= 1'b1;
        res  <= relu_clamp(new_acc, cfg_shift);
      end
    end
  end

endmodule

// File: rtl/psum_collector.sv
// psum_collector
//   Collects the eight MAC lanes: each lane accumulates over a configurable
//   number of tiles, results are packed into one word and handed to the
//   output writer over a valid/ready handshake.
//
//   clk, rst   : clock, synchronous active-high reset
//   psum_i     : lane k partial sum at [DW*k +: DW], signed
//   vld_i      : per-lane partial-sum valid
//   cfg_tiles  : tiles per output group (0 means 1)
//   cfg_shift  : arithmetic right shift before ReLU/clamp
//   dout       : packed results, lane k at [DW*k +: DW]
//   out_vld    : dout valid
//   out_rdy    : consumer ready
//   ovf_err    : sticky, a lane completed while its last result was undrained
//   grp_cnt    : accepted output words, wraps
//
// Handshake: a word transfers on every rising edge where out_vld and out_rdy
// are both high; out_vld stays high and dout stays stable until that edge,
// and out_vld does not depend combinationally on out_rdy.
module psum_collector
  import psum_collector_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [DW*LANES-1:0] psum_i,
  input  logic [LANES-1:0]    vld_i,
  input  logic [TW-1:0]       cfg_tiles,
  input  logic [2:0]          cfg_shift,
  output logic [DW*LANES-1:0] dout,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic                ovf_err,
  output logic [15:0]         grp_cnt
);

  state_t              state;
  logic [LANES-1:0]    done;
  logic [LANES-1:0]    ovf;
  logic [DW*LANES-1:0] res;
  logic                clr_done;

  assign clr_done = (state == ST_HOLD) && out_rdy;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    psum_lane_acc u_lane (
      .clk       (clk),
      .rst       (rst),
      .psum      (psum_i[DW*k +: DW]),
      .vld       (vld_i[k]),
      .cfg_tiles (cfg_tiles),
      .cfg_shift (cfg_shift),
      .clr_done  (clr_done),
      .done      (done[k]),
      .res       (res[DW*k +: DW]),
      .ovf       (ovf[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_COLLECT;
      dout    <= '0;
      out_vld <= 1'b0;
      ovf_err <= 1'b0;
      grp_cnt <= '0;
    end else begin
      if (|ovf) begin
        ovf_err <= 1'b1;
      end
      case (state)
        ST_COLLECT: begin
          if (&done) begin
            dout    <= res;
            out_vld <= 1'b1;
            state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_rdy) begin
            out_vld <= 1'b0;
            grp_cnt <= grp_cnt + 16'd1;
            state   <= ST_COLLECT;
          end
        end
        default: begin
          out_vld <= 1'b0;
          state   <= ST_COLLECT;
        end
      endcase
    end
  end

endmodule
